// File: rtl/axis_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axis_frame_pkg
// Description : Shared state encodings and byte-count helpers for AXI-Stream
//               framers.
// Revision    : 1.0 - initial release
// ============================================================================
package axis_frame_pkg;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_pass = 2'd1;
    localparam logic [1:0] c_st_drop = 2'd2;

    function automatic int unsigned popcount(input logic [63:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

    // Mask with the low n bits set; n >= 64 yields all ones.
    function automatic logic [63:0] low_mask(input int unsigned n);
        if (n >= 64) begin
            return '1;
        end
        return (64'd1 << n) - 64'd1;
    endfunction

    // Unsigned add clamped to the all-ones value of a w-bit field (w < 64).
    function automatic logic [63:0] len_sat_add(input logic [63:0] a,
                                                input logic [63:0] b,
                                                input int unsigned w);
        logic [63:0] sum;
        logic [63:0] max;
        sum = a + b;
        max = (64'd1 << w) - 64'd1;
        return (sum > max) ? max : sum;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_keep_count.sv
`default_nettype none
// ============================================================================
// Module      : axis_keep_count
// Description : tkeep popcount and low-byte keep mask generator.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_keep_count
    import axis_frame_pkg::*;
#(
    parameter int KEEP_WIDTH  = 4,
    parameter int KEEP_ENABLE = 1,
    parameter int LEN_WIDTH   = 16,
    parameter int CNT_WIDTH   = $clog2(KEEP_WIDTH + 1)
) (
    input  logic [KEEP_WIDTH-1:0] i_keep,
    input  logic [LEN_WIDTH-1:0]  i_mask_len,
    output logic [CNT_WIDTH-1:0]  o_beat_bytes,
    output logic [KEEP_WIDTH-1:0] o_keep_mask
);

    logic [31:0] w_len_clip;

    assign w_len_clip = (i_mask_len >= LEN_WIDTH'(KEEP_WIDTH)) ? 32'(KEEP_WIDTH)
                                                               : 32'(i_mask_len);
    assign o_keep_mask = i_keep & KEEP_WIDTH'(low_mask(w_len_clip));

    generate
        if (KEEP_ENABLE != 0) begin : g_keep
            assign o_beat_bytes = CNT_WIDTH'(popcount(64'(i_keep)));
        end else begin : g_no_keep
            assign o_beat_bytes = CNT_WIDTH'(1);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/axis_frame_len_limit.sv
`default_nettype none
// ============================================================================
// Module      : axis_frame_len_limit
// Description : AXI-Stream frame length monitor; truncates frames beyond a
//               per-frame byte limit and reports length/truncation status.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_frame_len_limit
    import axis_frame_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = (DATA_WIDTH + 7) / 8,
    parameter int ID_ENABLE   = 0,
    parameter int ID_WIDTH    = 8,
    parameter int DEST_ENABLE = 0,
    parameter int DEST_WIDTH  = 8,
    parameter int USER_ENABLE = 1,
    parameter int USER_WIDTH  = 1,
    parameter int LEN_WIDTH   = 16,
    parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_VALUE = 1'b1,
    parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_MASK  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [ID_WIDTH-1:0]   s_axis_tid,
    input  logic [DEST_WIDTH-1:0] s_axis_tdest,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [ID_WIDTH-1:0]   m_axis_tid,
    output logic [DEST_WIDTH-1:0] m_axis_tdest,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    input  logic [LEN_WIDTH-1:0]  cfg_max_len,
    output logic                  status_valid,
    output logic [LEN_WIDTH-1:0]  status_len,
    output logic                  status_truncated
);

    localparam int c_cnt_w = $clog2(KEEP_WIDTH + 1);

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [LEN_WIDTH-1:0]  r_count;
    logic [LEN_WIDTH-1:0]  r_lim;
    logic                  r_trunc;
    logic                  r_status_valid;
    logic [LEN_WIDTH-1:0]  r_status_len;
    logic                  r_status_trunc;

    logic [DATA_WIDTH-1:0] r_m_tdata;
    logic [KEEP_WIDTH-1:0] r_m_tkeep;
    logic                  r_m_tvalid;
    logic                  r_m_tlast;
    logic [ID_WIDTH-1:0]   r_m_tid;
    logic [DEST_WIDTH-1:0] r_m_tdest;
    logic [USER_WIDTH-1:0] r_m_tuser;

    logic [KEEP_WIDTH-1:0] w_keep_in;
    logic [KEEP_WIDTH-1:0] w_keep_mask;
    logic [c_cnt_w-1:0]    w_beat_bytes;
    logic [LEN_WIDTH-1:0]  w_cur_count;
    logic [LEN_WIDTH-1:0]  w_cur_lim;
    logic [LEN_WIDTH-1:0]  w_next;
    logic [LEN_WIDTH-1:0]  w_rem;
    logic                  w_accept;
    logic                  w_fwd;
    logic                  w_over;
    logic                  w_trunc_nxt;

    assign s_axis_tready = ~rst & ((r_state == c_st_drop) | ~r_m_tvalid | m_axis_tready);
    assign w_accept      = s_axis_tvalid & s_axis_tready;
    assign w_fwd         = w_accept & (r_state != c_st_drop);
    assign w_keep_in     = (KEEP_ENABLE != 0) ? s_axis_tkeep : '1;

    // A frame's first beat counts from zero against the live cfg value.
    assign w_cur_count = (r_state == c_st_idle) ? '0 : r_count;
    assign w_cur_lim   = (r_state == c_st_idle) ? cfg_max_len : r_lim;
    assign w_next      = LEN_WIDTH'(len_sat_add(64'(w_cur_count), 64'(w_beat_bytes), LEN_WIDTH));
    assign w_over      = (w_cur_lim != '0) && (w_next > w_cur_lim);
    assign w_rem       = w_cur_lim - w_cur_count;
    assign w_trunc_nxt = ((r_state != c_st_idle) & r_trunc) | w_over;

    axis_keep_count #(
        .KEEP_WIDTH  (KEEP_WIDTH),
        .KEEP_ENABLE (KEEP_ENABLE),
        .LEN_WIDTH   (LEN_WIDTH),
        .CNT_WIDTH   (c_cnt_w)
    ) u_keep_count (
        .i_keep       (w_keep_in),
        .i_mask_len   (w_rem),
        .o_beat_bytes (w_beat_bytes),
        .o_keep_mask  (w_keep_mask)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_tdata  <= '0;
            r_m_tkeep  <= '0;
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
            r_m_tid    <= '0;
            r_m_tdest  <= '0;
            r_m_tuser  <= '0;
        end else if (w_fwd) begin
            r_m_tdata  <= s_axis_tdata;
            r_m_tkeep  <= w_over ? w_keep_mask : w_keep_in;
            r_m_tvalid <= 1'b1;
            r_m_tlast  <= s_axis_tlast | w_over;
            r_m_tid    <= s_axis_tid;
            r_m_tdest  <= s_axis_tdest;
            r_m_tuser  <= w_over ? (s_axis_tuser | (USER_BAD_FRAME_VALUE & USER_BAD_FRAME_MASK))
                                 : s_axis_tuser;
        end else if (m_axis_tready) begin
            r_m_tvalid <= 1'b0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle, c_st_pass: begin
                if (w_accept) begin
                    if (s_axis_tlast) begin
                        w_state_nxt = c_st_idle;
                    end else if (w_over) begin
                        w_state_nxt = c_st_drop;
                    end else begin
                        w_state_nxt = c_st_pass;
                    end
                end
            end
            c_st_drop: begin
                if (w_accept && s_axis_tlast) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= c_st_idle;
            r_count        <= '0;
            r_lim          <= '0;
            r_trunc        <= 1'b0;
            r_status_valid <= 1'b0;
            r_status_len   <= '0;
            r_status_trunc <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_status_valid <= 1'b0;
            if (w_accept) begin
                r_count <= w_next;
                r_trunc <= w_trunc_nxt;
                if (r_state == c_st_idle) begin
                    r_lim <= cfg_max_len;
                end
                if (s_axis_tlast) begin
                    r_status_valid <= 1'b1;
                    r_status_len   <= w_next;
                    r_status_trunc <= w_trunc_nxt;
                end
            end
        end
    end

    assign m_axis_tdata     = r_m_tdata;
    assign m_axis_tkeep     = r_m_tkeep;
    assign m_axis_tvalid    = r_m_tvalid;
    assign m_axis_tlast     = r_m_tlast;
    assign m_axis_tid       = (ID_ENABLE != 0)   ? r_m_tid   : '0;
    assign m_axis_tdest     = (DEST_ENABLE != 0) ? r_m_tdest : '0;
    assign m_axis_tuser     = (USER_ENABLE != 0) ? r_m_tuser : '0;
    assign status_valid     = r_status_valid;
    assign status_len       = r_status_len;
    assign status_truncated = r_status_trunc;

endmodule
`default_nettype wire
